// File: rtl/axi_adc_jesd204_pn_pkg.sv
// Shared definitions for the JESD204 ADC PN checker.
// Holds the PN select encodings, the polynomial taps, the lock FSM state type
// and the serial PN next-bit function.
// History convention: the newest bit is at bit 0, so bit k-1 holds the bit from k steps ago.
package axi_adc_jesd204_pn_pkg;

   localparam int unsigned PN_HIST_W = 32;
   localparam int unsigned PN_SEL_W  = 4;

   localparam logic [PN_SEL_W-1:0] PN_SEL_PN9  = 4'd0;
   localparam logic [PN_SEL_W-1:0] PN_SEL_PN23 = 4'd1;
   localparam logic [PN_SEL_W-1:0] PN_SEL_PN7  = 4'd2;
   localparam logic [PN_SEL_W-1:0] PN_SEL_PN15 = 4'd3;
   localparam logic [PN_SEL_W-1:0] PN_SEL_PN31 = 4'd4;

   // Polynomial x^HI + x^LO + 1, so b[t] = b[t-HI] ^ b[t-LO]
   localparam int unsigned PN7_TAP_HI  = 7;
   localparam int unsigned PN7_TAP_LO  = 6;
   localparam int unsigned PN9_TAP_HI  = 9;
   localparam int unsigned PN9_TAP_LO  = 5;
   localparam int unsigned PN15_TAP_HI = 15;
   localparam int unsigned PN15_TAP_LO = 14;
   localparam int unsigned PN23_TAP_HI = 23;
   localparam int unsigned PN23_TAP_LO = 18;
   localparam int unsigned PN31_TAP_HI = 31;
   localparam int unsigned PN31_TAP_LO = 28;

   typedef enum logic {
      OOS    = 1'b0,
      LOCKED = 1'b1
   } pn_state_e;

   // Only encodings 0..4 select a sequence
   function automatic logic pn_sel_valid(input logic [PN_SEL_W-1:0] sel);
      return (sel <= PN_SEL_PN31);
   endfunction

   // Next sequence bit for the given history; reserved selects produce 0
   function automatic logic pn_next_bit(input logic [PN_HIST_W-1:0] history,
                                        input logic [PN_SEL_W-1:0]  sel);
      logic nb;
      nb = 1'b0;
      case (sel)
         PN_SEL_PN7:  nb = history[PN7_TAP_HI-1]  ^ history[PN7_TAP_LO-1];
         PN_SEL_PN9:  nb = history[PN9_TAP_HI-1]  ^ history[PN9_TAP_LO-1];
         PN_SEL_PN15: nb = history[PN15_TAP_HI-1] ^ history[PN15_TAP_LO-1];
         PN_SEL_PN23: nb = history[PN23_TAP_HI-1] ^ history[PN23_TAP_LO-1];
         PN_SEL_PN31: nb = history[PN31_TAP_HI-1] ^ history[PN31_TAP_LO-1];
         default:     nb = 1'b0;
      endcase
      return nb;
   endfunction

endpackage

// File: rtl/axi_adc_jesd204_pn_gen.sv
// Combinational expected-beat generator.
// Ports:
//   history_i     32-bit PN history, newest bit at bit 0
//   sel_i         PN sequence select
//   expected_o_c  next beat in sample layout (sample 0 low, each sample MSB first in time)
//   hist_next_o_c history after the generated bits were shifted in
module axi_adc_jesd204_pn_gen
   import axi_adc_jesd204_pn_pkg::*;
#(
   parameter int unsigned CHANNEL_WIDTH   = 14,
   parameter int unsigned DATA_PATH_WIDTH = 2
) (
   input  logic [PN_HIST_W-1:0]                      history_i,
   input  logic [PN_SEL_W-1:0]                       sel_i,
   output logic [CHANNEL_WIDTH*DATA_PATH_WIDTH-1:0]  expected_o_c,
   output logic [PN_HIST_W-1:0]                      hist_next_o_c
);

   localparam int unsigned W = CHANNEL_WIDTH * DATA_PATH_WIDTH;

   logic [PN_HIST_W-1:0] hist;
   logic [W-1:0]         time_bits;
   logic                 nb;

   // Serial unroll: the first generated bit ends up at time_bits[W-1]
   always_comb begin
      hist      = history_i;
      time_bits = '0;
      nb        = 1'b0;
      for (int unsigned t = 0; t < W; t++) begin
         nb        = pn_next_bit(hist, sel_i);
         hist      = {hist[PN_HIST_W-2:0], nb};
         time_bits = W'({time_bits, nb});
      end
   end

   assign hist_next_o_c = hist;

   // Time order to sample layout: sample 0 takes the earliest bits
   for (genvar n = 0; n < DATA_PATH_WIDTH; n++) begin : g_smp
      assign expected_o_c[n*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
         time_bits[W-1-n*CHANNEL_WIDTH -: CHANNEL_WIDTH];
   end

endmodule

// File: rtl/axi_adc_jesd204_pn_checker.sv
// Self-synchronising PN checker for one JESD204 ADC converter channel.
// Ports:
//   adc_clk, adc_rst   channel clock; synchronous active-high reset
//   adc_valid          beat qualifier for adc_data
//   adc_data           DATA_PATH_WIDTH samples, sample 0 in the low bits (oldest)
//   adc_pnseq_sel      0 PN9, 1 PN23, 2 PN7, 3 PN15, 4 PN31, others reserved
//   adc_err_clr        pulse, clears the error counter
//   adc_pn_oos         1 = not locked
//   adc_pn_err         1-cycle pulse on a mismatching beat while locked
//   adc_pn_err_cnt     saturating count of mismatching beats while locked
module axi_adc_jesd204_pn_checker
   import axi_adc_jesd204_pn_pkg::*;
#(
   parameter int unsigned CHANNEL_WIDTH   = 14,
   parameter int unsigned DATA_PATH_WIDTH = 2,
   parameter int unsigned TWOS_COMPLEMENT = 1,
   parameter int unsigned OOS_THRESHOLD   = 16,
   parameter int unsigned ERR_CNT_WIDTH   = 32
) (
   input  logic                                     adc_clk,
   input  logic                                     adc_rst,
   input  logic                                     adc_valid,
   input  logic [CHANNEL_WIDTH*DATA_PATH_WIDTH-1:0] adc_data,
   input  logic [PN_SEL_W-1:0]                      adc_pnseq_sel,
   input  logic                                     adc_err_clr,
   output logic                                     adc_pn_oos,
   output logic                                     adc_pn_err,
   output logic [ERR_CNT_WIDTH-1:0]                 adc_pn_err_cnt
);

   localparam int unsigned W     = CHANNEL_WIDTH * DATA_PATH_WIDTH;
   localparam int unsigned RUN_W = 8;
   localparam logic [RUN_W-1:0]         RUN_LAST = RUN_W'(OOS_THRESHOLD - 1);
   localparam logic [CHANNEL_WIDTH-1:0] SMP_MASK =
      CHANNEL_WIDTH'(TWOS_COMPLEMENT != 0) << (CHANNEL_WIDTH - 1);

   logic [W-1:0]          d1_q, d1_d;
   logic                  valid1_q, valid1_d;
   logic [PN_SEL_W-1:0]   sel_q, sel_d;
   logic [PN_HIST_W-1:0]  history_q, history_d;
   pn_state_e             state_q, state_d;
   logic [RUN_W-1:0]      run_q, run_d;
   logic                  oos_q, oos_d;
   logic                  err_q, err_d;
   logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [W-1:0]          fmt;
   logic [W-1:0]          rx_time;
   logic [W-1:0]          expected_c;
   logic [PN_HIST_W-1:0]  hist_exp_c;
   logic [PN_HIST_W-1:0]  hist_rx_c;
   logic                  sel_chg;
   logic                  beat_match;

   // PN is defined on offset binary; also reorder the held beat into time order
   for (genvar n = 0; n < DATA_PATH_WIDTH; n++) begin : g_smp
      assign fmt[n*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
         adc_data[n*CHANNEL_WIDTH +: CHANNEL_WIDTH] ^ SMP_MASK;
      assign rx_time[W-1-n*CHANNEL_WIDTH -: CHANNEL_WIDTH] =
         d1_q[n*CHANNEL_WIDTH +: CHANNEL_WIDTH];
   end

   // History after shifting in the received beat (keeps the newest 32 bits)
   if (W >= PN_HIST_W) begin : g_hist_wide
      assign hist_rx_c = rx_time[PN_HIST_W-1:0];
   end else begin : g_hist_narrow
      assign hist_rx_c = {history_q[PN_HIST_W-1-W:0], rx_time};
   end

   axi_adc_jesd204_pn_gen #(
      .CHANNEL_WIDTH   (CHANNEL_WIDTH),
      .DATA_PATH_WIDTH (DATA_PATH_WIDTH)
   ) u_gen (
      .history_i     (history_q),
      .sel_i         (sel_q),
      .expected_o_c  (expected_c),
      .hist_next_o_c (hist_exp_c)
   );

   // Next-state: lock FSM, run counter, history update and error counter
   always_comb begin
      sel_chg    = (adc_pnseq_sel != sel_q);
      // an all-zero history can only predict zeros, so it never counts as a match
      beat_match = (d1_q == expected_c) && (history_q != '0);
      d1_d       = adc_valid ? fmt : d1_q;
      valid1_d   = adc_valid;
      sel_d      = adc_pnseq_sel;
      history_d  = history_q;
      state_d    = state_q;
      run_d      = run_q;
      err_d      = 1'b0;
      cnt_d      = cnt_q;

      if (sel_chg) begin
         state_d   = OOS;
         run_d     = '0;
         history_d = '0;
      end else if (!pn_sel_valid(sel_q)) begin
         state_d = OOS;
         run_d   = '0;
      end else if (valid1_q) begin
         case (state_q)
            OOS: begin
               history_d = hist_rx_c;
               if (!beat_match) begin
                  run_d = '0;
               end else if (run_q == RUN_LAST) begin
                  state_d = LOCKED;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 1'b1;
               end
            end
            LOCKED: begin
               // locked: keep predicting from our own sequence, ignore received bits
               history_d = hist_exp_c;
               if (beat_match) begin
                  run_d = '0;
               end else begin
                  err_d = 1'b1;
                  if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                  if (run_q == RUN_LAST) begin
                     state_d = OOS;
                     run_d   = '0;
                  end else begin
                     run_d = run_q + 1'b1;
                  end
               end
            end
            default: state_d = OOS;
         endcase
      end

      if (adc_err_clr) cnt_d = '0;
      oos_d = (state_d == OOS);
   end

   // State registers
   always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
         d1_q      <= '0;
         valid1_q  <= 1'b0;
         sel_q     <= '0;
         history_q <= '0;
         state_q   <= OOS;
         run_q     <= '0;
         oos_q     <= 1'b1;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         d1_q      <= d1_d;
         valid1_q  <= valid1_d;
         sel_q     <= sel_d;
         history_q <= history_d;
         state_q   <= state_d;
         run_q     <= run_d;
         oos_q     <= oos_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign adc_pn_oos     = oos_q;
   assign adc_pn_err     = err_q;
   assign adc_pn_err_cnt = cnt_q;

endmodule

// File: tb/tb_axi_adc_jesd204_pn_checker.sv
// Scoreboard bench for the PN checker: a queue-based sequence model predicts the
// registered outputs for every cycle; a monitor compares them one cycle later.
module tb_axi_adc_jesd204_pn_checker;

   localparam int unsigned CW      = 14;
   localparam int unsigned DPW     = 2;
   localparam int unsigned W       = CW * DPW;
   localparam int unsigned THR     = 16;
   localparam int unsigned ECW     = 6;
   localparam int unsigned CNT_MAX = (1 << ECW) - 1;
   localparam logic [3:0] S_PN9 = 4'd0, S_PN23 = 4'd1, S_PN7 = 4'd2, S_PN15 = 4'd3, S_PN31 = 4'd4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst   = 1'b1;
   logic           valid = 1'b0;
   logic           clr   = 1'b0;
   logic [W-1:0]   data  = '0;
   logic [3:0]     sel   = '0;
   logic           oos, err;
   logic [ECW-1:0] cnt;

   axi_adc_jesd204_pn_checker #(
      .CHANNEL_WIDTH   (CW),
      .DATA_PATH_WIDTH (DPW),
      .TWOS_COMPLEMENT (1),
      .OOS_THRESHOLD   (THR),
      .ERR_CNT_WIDTH   (ECW)
   ) u_dut (
      .adc_clk        (clk),
      .adc_rst        (rst),
      .adc_valid      (valid),
      .adc_data       (data),
      .adc_pnseq_sel  (sel),
      .adc_err_clr    (clr),
      .adc_pn_oos     (oos),
      .adc_pn_err     (err),
      .adc_pn_err_cnt (cnt)
   );

   typedef struct packed {
      logic           oos;
      logic           err;
      logic [ECW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   logic [W-1:0] fmt_mask;
   bit           m_locked;
   int           m_run;
   int           m_cnt;
   logic [3:0]   m_sel;
   bit           m_pv;
   logic [W-1:0] m_pd;
   bit           m_err;
   bit           m_hist[$];   // last 32 bits, oldest first
   bit           tx_hist[$];

   function automatic void taps(input logic [3:0] s, output int n, output int m);
      case (s)
         4'd0:    begin n = 9;  m = 5;  end
         4'd1:    begin n = 23; m = 18; end
         4'd2:    begin n = 7;  m = 6;  end
         4'd3:    begin n = 15; m = 14; end
         4'd4:    begin n = 31; m = 28; end
         default: begin n = 0;  m = 0;  end
      endcase
   endfunction

   // b[t] = b[t-n] ^ b[t-m]; the bit k steps back sits at index 32-k
   function automatic bit next_bit(input bit h[$], input logic [3:0] s);
      int n, m;
      taps(s, n, m);
      if (n == 0) return 1'b0;
      return h[32-n] ^ h[32-m];
   endfunction

   // tv[t] = bit at time t (sample 0 first, MSB first)
   function automatic logic [W-1:0] to_time(input logic [W-1:0] d);
      logic [W-1:0] tv;
      for (int n = 0; n < DPW; n++)
         for (int k = 0; k < CW; k++)
            tv[n*CW+k] = d[n*CW+CW-1-k];
      return tv;
   endfunction

   function automatic logic [W-1:0] from_time(input logic [W-1:0] tv);
      logic [W-1:0] d;
      for (int n = 0; n < DPW; n++)
         for (int k = 0; k < CW; k++)
            d[n*CW+CW-1-k] = tv[n*CW+k];
      return d;
   endfunction

   task automatic tx_seed(input logic [31:0] seed);
      tx_hist.delete();
      for (int i = 31; i >= 0; i--) tx_hist.push_back(seed[i]);
   endtask

   task automatic tx_beat(input logic [3:0] s, output logic [W-1:0] d);
      logic [W-1:0] tv;
      bit nb;
      for (int t = 0; t < W; t++) begin
         nb = next_bit(tx_hist, s);
         tv[t] = nb;
         tx_hist.push_back(nb);
         void'(tx_hist.pop_front());
      end
      d = from_time(tv) ^ fmt_mask;
   endtask

   // Effect of the coming clock edge, given the inputs just driven
   function automatic void model_edge();
      logic [W-1:0] rx, ex;
      bit h2[$];
      bit hz, nb, match;
      m_err = 1'b0;
      if (rst) begin
         m_locked = 1'b0; m_run = 0; m_cnt = 0; m_pv = 1'b0; m_sel = sel;
         m_hist.delete();
         repeat (32) m_hist.push_back(1'b0);
         return;
      end
      if (sel != m_sel) begin
         m_locked = 1'b0; m_run = 0; m_sel = sel;
         m_hist.delete();
         repeat (32) m_hist.push_back(1'b0);
      end else if (m_sel > 4'd4) begin
         m_locked = 1'b0; m_run = 0;
      end else if (m_pv) begin
         rx = to_time(m_pd ^ fmt_mask);
         hz = 1'b1;
         foreach (m_hist[i]) if (m_hist[i]) hz = 1'b0;
         h2 = m_hist;
         for (int t = 0; t < W; t++) begin
            nb = next_bit(h2, m_sel);
            ex[t] = nb;
            h2.push_back(nb);
            void'(h2.pop_front());
         end
         match = (rx == ex) && !hz;
         if (!m_locked) begin
            for (int t = 0; t < W; t++) begin
               m_hist.push_back(rx[t]);
               void'(m_hist.pop_front());
            end
            if (match) begin
               m_run++;
               if (m_run == THR) begin m_locked = 1'b1; m_run = 0; end
            end else begin
               m_run = 0;
            end
         end else begin
            m_hist = h2;
            if (match) begin
               m_run = 0;
            end else begin
               m_err = 1'b1;
               if (m_cnt < CNT_MAX) m_cnt++;
               m_run++;
               if (m_run == THR) begin m_locked = 1'b0; m_run = 0; end
            end
         end
      end
      if (clr) m_cnt = 0;
      m_pv = valid;
      m_pd = data;
   endfunction

   task automatic step(input bit v, input logic [W-1:0] d, input logic [3:0] s,
                       input bit c, input bit r);
      exp_t e;
      @(negedge clk);
      valid = v; data = d; sel = s; clr = c; rst = r;
      model_edge();
      e.oos = !m_locked;
      e.err = m_err;
      e.cnt = ECW'(m_cnt);
      exp_q.push_back(e);
   endtask

   task automatic pn_beats(input int n, input logic [3:0] s);
      logic [W-1:0] d;
      repeat (n) begin
         tx_beat(s, d);
         step(1'b1, d, s, 1'b0, 1'b0);
      end
   endtask

   task automatic bad_beats(input int n, input logic [3:0] s);
      logic [W-1:0] d, x;
      repeat (n) begin
         tx_beat(s, d);
         x = W'($urandom());
         if (x == '0) x = W'(1);
         step(1'b1, d ^ x, s, 1'b0, 1'b0);
      end
   endtask

   // Monitor: one expected entry per cycle, sampled just after the edge
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (oos !== e.oos) begin
               failures++;
               $display("FAIL oos t=%0t got=%b exp=%b", $time, oos, e.oos);
            end
            checks++;
            if (err !== e.err) begin
               failures++;
               $display("FAIL err t=%0t got=%b exp=%b", $time, err, e.err);
            end
            checks++;
            if (cnt !== e.cnt) begin
               failures++;
               $display("FAIL err_cnt t=%0t got=%0d exp=%0d", $time, cnt, e.cnt);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [W-1:0] d;
      fmt_mask = '0;
      for (int n = 0; n < DPW; n++) fmt_mask[n*CW+CW-1] = 1'b1;

      repeat (3) step(1'b0, '0, S_PN9, 1'b0, 1'b1);
      repeat (2) step(1'b0, '0, S_PN9, 1'b0, 1'b0);

      // PN9 clean from seed 0x1FF
      tx_seed(32'h1FF);
      pn_beats(40, S_PN9);

      // all-zero (formatted) input: loses lock and never relocks
      repeat (40) step(1'b1, fmt_mask, S_PN9, 1'b0, 1'b0);

      // PN23 with one flipped bit
      tx_seed($urandom() | 32'h1);
      pn_beats(100, S_PN23);
      tx_beat(S_PN23, d);
      step(1'b1, d ^ (W'(1) << $urandom_range(W - 1)), S_PN23, 1'b0, 1'b0);
      pn_beats(20, S_PN23);

      // PN15: 16 corrupted beats drop lock, clean data relocks
      tx_seed($urandom() | 32'h1);
      pn_beats(40, S_PN15);
      bad_beats(16, S_PN15);
      pn_beats(40, S_PN15);

      // PN31 with valid toggling each cycle
      tx_seed($urandom() | 32'h1);
      for (int i = 0; i < 80; i++) begin
         if (i % 2 == 0) pn_beats(1, S_PN31);
         else step(1'b0, W'($urandom()), S_PN31, 1'b0, 1'b0);
      end

      // PN7: drive the counter into saturation, then clear against an error
      tx_seed($urandom() | 32'h1);
      pn_beats(40, S_PN7);
      repeat (5) begin
         bad_beats(15, S_PN7);
         pn_beats(1, S_PN7);
      end
      bad_beats(1, S_PN7);
      tx_beat(S_PN7, d);
      step(1'b1, d ^ W'(1), S_PN7, 1'b1, 1'b0);
      bad_beats(2, S_PN7);
      pn_beats(5, S_PN7);

      // sequence change while locked, then reserved select
      tx_seed(32'h1FF);
      pn_beats(30, S_PN9);
      repeat (20) step(1'b1, W'($urandom()), 4'd7, 1'b0, 1'b0);
      pn_beats(30, S_PN9);

      // reset mid-stream
      repeat (2) begin
         tx_beat(S_PN9, d);
         step(1'b1, d, S_PN9, 1'b0, 1'b1);
      end
      pn_beats(30, S_PN9);
      repeat (3) step(1'b0, '0, S_PN9, 1'b0, 1'b0);

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
